miinst_queue: RTL
=================

MIINST_QUEUE -- requirements
Module: miinst_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 16, giving queue capacity in micro-instructions; it SHALL be a power of two and at least 2*`MQ_N.
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1; reset is synchronous and active-high.
REQ-004 SHALL have port flush, input, 1: discard all queued entries (redirect or jump taken).
REQ-005 SHALL have port in_valid, input, 1: the fetch phase presents a completed instruction's micro-instruction bundle.
REQ-006 SHALL have port in_miinst, input, miinst_t[`MQ_N-1:0]: bundle slots in program order; MIOP_NOP marks an empty slot.
REQ-007 SHALL have port in_ready, output, 1: queue can accept a full bundle.
REQ-008 SHALL have port out_valid, output, 1: head entry is valid.
REQ-009 SHALL have port out_miinst, output, miinst_t: head micro-instruction.
REQ-010 SHALL have port out_ready, input, 1: consumer accepts the head this cycle.
REQ-011 SHALL have port count, output, $clog2(DEPTH+1): number of occupied entries.

Function
REQ-012 Push SHALL occur when in_valid && in_ready && !flush.
REQ-013 On push, non-NOP slots SHALL be written at consecutive tail positions in ascending slot index order, skipping NOP slots; k = number of non-NOP slots, 0..`MQ_N.
REQ-014 An all-NOP bundle SHALL be accepted and write nothing (k=0).
REQ-015 in_ready SHALL be high iff (DEPTH - count) >= `MQ_N, independent of bundle content; it is a registered-state function with no combinational dependency on in_valid or in_miinst.
REQ-016 Pop SHALL occur when out_valid && out_ready && !flush; the head pointer advances by 1.
REQ-017 out_valid SHALL equal (count != 0); out_miinst SHALL be the head entry (first-word-fall-through from storage).
REQ-018 When count==0, out_miinst SHALL be a NOP: opcode MIOP_NOP, all other fields 0.
REQ-019 There is no write-to-read bypass: an entry pushed in cycle N SHALL first appear on out_miinst in cycle N+1.
REQ-020 On simultaneous push and pop, count next SHALL equal count + k - 1.
REQ-021 Head and tail pointers SHALL wrap modulo DEPTH; a bundle straddling the wrap boundary SHALL be written contiguously across it.
REQ-022 flush SHALL take priority over push and pop: next cycle, count=0, head=tail=0, and the same-cycle bundle is dropped.
REQ-023 The consumer SHALL observe order preserved exactly: program order across bundles, and slot order within a bundle.
REQ-024 Popping when empty and pushing when !in_ready SHALL be ignored, with no state change.

Reset
REQ-025 While rst is high at a clock edge: head=0, tail=0, count=0.
REQ-026 After reset: out_valid=0, out_miinst=NOP, in_ready=1.
REQ-027 Storage contents need not be reset.
REQ-028 rst SHALL dominate flush, push and pop in the same cycle.

Structure
REQ-029 miinst_t, MIOP_NOP, `MQ_N and bmd_t SHALL come from the shared common params header/package; no local redefinition.
REQ-030 The compaction logic SHALL be one combinational sub-module, miinst_compactor. It takes the bundle and outputs packed slots plus k.
REQ-031 Storage SHALL be a DEPTH-entry register array with a `MQ_N-wide write port and a 1-wide read port.

Verification
REQ-032 Reset, then push bundle {ADD, NOP, NOP, NOP} -> next cycle count=1, out_miinst.opcode=MIOP_ADD, out_valid=1.
REQ-033 Push {MOVI, ADDI, STORE, NOP} (PUSH imm) with out_ready=1 -> pops return MOVI, ADDI, STORE on consecutive cycles, then out_valid=0.
REQ-034 DEPTH=16, `MQ_N=4: fill to count=13 -> in_ready=0. Pop once -> count=12, in_ready=1.
REQ-035 Advance tail to 14, then push 4 non-NOP entries -> they occupy indices 14, 15, 0, 1 and drain in order.
REQ-036 count=5, flush with in_valid=1 and out_ready=1 in the same cycle -> next cycle count=0 and out_valid=0; the bundle is not enqueued.
REQ-037 count=3, push k=2 with a simultaneous pop -> count=4; all-NOP push -> count unchanged.

Source files
------------

// File: rtl/miinst_queue_pkg.sv
// Shared micro-instruction types and bundle width for the decode-side queue.
// Everything that names a micro-op or the bundle width pulls it from here.
package miinst_queue_pkg;

`ifndef MQ_N
`define MQ_N 4
`endif

  localparam int MQ_N  = `MQ_N;
  localparam int MQ_KW = $clog2(MQ_N + 1);

  typedef enum logic [3:0] {
    MIOP_NOP   = 4'd0,
    MIOP_ADD   = 4'd1,
    MIOP_SUB   = 4'd2,
    MIOP_ADDI  = 4'd3,
    MIOP_MOVI  = 4'd4,
    MIOP_LOAD  = 4'd5,
    MIOP_STORE = 4'd6,
    MIOP_BR    = 4'd7
  } miop_t;

  // Branch metadata carried alongside each micro-op.
  typedef struct packed {
    logic       taken;
    logic [7:0] target;
  } bmd_t;

  typedef struct packed {
    miop_t       opcode;
    logic [3:0]  rd;
    logic [3:0]  rs1;
    logic [3:0]  rs2;
    logic [15:0] imm;
    bmd_t        bmd;
  } miinst_t;

  // MIOP_NOP encodes as zero, so an all-zero word is the canonical empty entry.
  localparam miinst_t MIINST_NOP = '0;

  function automatic logic is_nop(input miinst_t m);
    return m.opcode == MIOP_NOP;
  endfunction

endpackage

// File: rtl/miinst_compactor.sv
// Squeezes the NOP holes out of a fetch bundle: live slots are packed toward
// slot 0 in their original order, and k reports how many survived.
module miinst_compactor
  import miinst_queue_pkg::*;
(
  input  miinst_t [MQ_N-1:0] in_bundle,
  output miinst_t [MQ_N-1:0] packed_slots,
  output logic [MQ_KW-1:0]   k
);

  logic [MQ_N-1:0]  slot_live;
  logic [MQ_KW-1:0] pos [MQ_N];

  genvar gi;
  generate
    for (gi = 0; gi < MQ_N; gi++) begin : g_live
      assign slot_live[gi] = !is_nop(in_bundle[gi]);
    end
  endgenerate

  // pos[i] is the number of live slots ahead of slot i, i.e. its packed index.
  always_comb begin
    logic [MQ_KW-1:0] run;
    run = '0;
    for (int i = 0; i < MQ_N; i++) begin
      pos[i] = run;
      if (slot_live[i]) begin
        run = run + 1'b1;
      end
    end
    k = run;
  end

  always_comb begin
    packed_slots = '0;
    for (int j = 0; j < MQ_N; j++) begin
      for (int i = j; i < MQ_N; i++) begin
        if (slot_live[i] && (pos[i] == MQ_KW'(j))) begin
          packed_slots[j] = in_bundle[i];
        end
      end
    end
  end

endmodule

// File: rtl/miinst_queue.sv
// Micro-instruction queue between fetch and issue: accepts a whole compacted
// bundle per cycle and hands out one micro-op per cycle, first-word-fall-through.
module miinst_queue
  import miinst_queue_pkg::*;
#(
  parameter int DEPTH = 16
)
(
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       in_valid,
  input  miinst_t [MQ_N-1:0]         in_miinst,
  output logic                       in_ready,
  output logic                       out_valid,
  output miinst_t                    out_miinst,
  input  logic                       out_ready,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;

  miinst_t mem_q [DEPTH];

  miinst_t [MQ_N-1:0] packed_slots;
  logic [MQ_KW-1:0]   k;
  logic               push_en;
  logic               pop_en;
  logic [CW:0]        free_slots;

  logic [PW-1:0]      wr_addr [MQ_N];
  logic [MQ_N-1:0]    wr_en;

  miinst_compactor u_compactor (
    .in_bundle    (in_miinst),
    .packed_slots (packed_slots),
    .k            (k)
  );

  // Readiness depends only on occupancy, so producers never see a loop through in_miinst.
  assign free_slots = (CW+1)'(DEPTH) - {1'b0, count_q};
  assign in_ready   = free_slots >= (CW+1)'(MQ_N);
  assign out_valid  = count_q != '0;
  assign count      = count_q;

  assign push_en = in_valid && in_ready && !flush;
  assign pop_en  = out_valid && out_ready && !flush;

  assign out_miinst = out_valid ? mem_q[head_q] : MIINST_NOP;

  // Packed slot j lands at tail+j; the PW-bit add wraps a bundle across the end of the array.
  genvar gi;
  generate
    for (gi = 0; gi < MQ_N; gi++) begin : g_wr_port
      assign wr_addr[gi] = tail_q + PW'(gi);
      assign wr_en[gi]   = push_en && (MQ_KW'(gi) < k);
    end
  endgenerate

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
    end else begin
      if (push_en) begin
        tail_d = tail_q + PW'(k);
      end
      if (pop_en) begin
        head_d = head_q + 1'b1;
      end
      count_d = count_q + (push_en ? CW'(k) : '0) - (pop_en ? CW'(1) : '0);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Storage carries no reset; occupancy alone decides what is visible.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int j = 0; j < MQ_N; j++) begin
        if (wr_en[j]) begin
          mem_q[wr_addr[j]] <= packed_slots[j];
        end
      end
    end
  end

endmodule
